// File: rtl/goertzel_multibin_core.sv
// Time-multiplexed Goertzel recursion over N_BINS bins; each DPRAM sample is
// fetched once and applied to every bin before the next address is issued.
module goertzel_multibin_core #(
    parameter int D_W    = 16,
    parameter int B_W    = 8,
    parameter int FRAC   = 14,
    parameter int N_BINS = 4,
    parameter int A_W    = 9
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [A_W-1:0]        block_len,
    input  logic                  coeff_wr,
    input  logic [3:0]            coeff_idx,
    input  logic signed [D_W-1:0] coeff_data,
    input  logic [B_W-1:0]        data_n,
    output logic [A_W-1:0]        read_address,
    output logic                  busy,
    output logic                  res_valid,
    output logic [3:0]            res_bin,
    output logic signed [D_W-1:0] res_T1,
    output logic signed [D_W-1:0] res_T2,
    output logic                  done
);

    localparam int BI_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;
    localparam int P_W  = 2 * D_W;
    localparam logic [BI_W-1:0] LAST_BIN = BI_W'(N_BINS - 1);
    localparam logic [BI_W-1:0] ZERO_BIN = {BI_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_BIN   = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BI_W-1:0]       bin_q, bin_d;
    logic [A_W-1:0]        addr_q, addr_d;
    logic [A_W-1:0]        len_q, len_d;
    logic signed [D_W-1:0] coeff_q [N_BINS];
    logic signed [D_W-1:0] coeff_d [N_BINS];
    logic signed [D_W-1:0] t1_q [N_BINS];
    logic signed [D_W-1:0] t1_d [N_BINS];
    logic signed [D_W-1:0] t2_q [N_BINS];
    logic signed [D_W-1:0] t2_d [N_BINS];
    logic                  busy_q, busy_d;
    logic                  res_valid_q, res_valid_d;
    logic [3:0]            res_bin_q, res_bin_d;
    logic signed [D_W-1:0] res_t1_q, res_t1_d;
    logic signed [D_W-1:0] res_t2_q, res_t2_d;
    logic                  done_q, done_d;

    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] prod_sh_s;
    logic signed [D_W-1:0] s_s;
    logic [BI_W-1:0]       bin_nx_s;
    logic                  idx_ok_s;

    // Recursion datapath for the bin currently selected by bin_q
    always_comb begin
        prod_s    = P_W'(coeff_q[bin_q]) * P_W'(t1_q[bin_q]);
        prod_sh_s = prod_s >>> FRAC;
        s_s       = prod_sh_s[D_W-1:0] + D_W'(data_n) - t2_q[bin_q];
        bin_nx_s  = bin_q + BI_W'(1);
        idx_ok_s  = ({1'b0, coeff_idx} < 5'(N_BINS));
    end

    // Sequencer, coefficient/state file updates and result beat generation
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        addr_d      = addr_q;
        len_d       = len_q;
        coeff_d     = coeff_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        res_valid_d = res_valid_q;
        res_bin_d   = res_bin_q;
        res_t1_d    = res_t1_q;
        res_t2_d    = res_t2_q;
        done_d      = done_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (coeff_wr && idx_ok_s) begin
                        coeff_d[coeff_idx[BI_W-1:0]] = coeff_data;
                    end else begin
                        coeff_d = coeff_q;
                    end
                    if (start) begin
                        len_d   = block_len;
                        addr_d  = {A_W{1'b0}};
                        bin_d   = ZERO_BIN;
                        state_d = S_FETCH;
                        for (int i = 0; i < N_BINS; i++) begin
                            t1_d[i] = {D_W{1'b0}};
                            t2_d[i] = {D_W{1'b0}};
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    bin_d   = ZERO_BIN;
                    state_d = S_BIN;
                end
                S_BIN: begin
                    t2_d[bin_q] = t1_q[bin_q];
                    t1_d[bin_q] = s_s;
                    if (bin_q == LAST_BIN) begin
                        if (addr_q == len_q) begin
                            // Beat 0 may be the bin being written this cycle
                            bin_d       = ZERO_BIN;
                            state_d     = S_POST;
                            res_valid_d = 1'b1;
                            res_bin_d   = 4'd0;
                            res_t1_d    = (bin_q == ZERO_BIN) ? s_s : t1_q[ZERO_BIN];
                            res_t2_d    = (bin_q == ZERO_BIN) ? t1_q[bin_q] : t2_q[ZERO_BIN];
                        end else begin
                            addr_d  = addr_q + A_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        bin_d = bin_nx_s;
                    end
                end
                S_POST: begin
                    if (bin_q == LAST_BIN) begin
                        res_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        bin_d     = bin_nx_s;
                        res_bin_d = 4'(bin_nx_s);
                        res_t1_d  = t1_q[bin_nx_s];
                        res_t2_d  = t2_q[bin_nx_s];
                    end
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    res_valid_d = 1'b0;
                    done_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State register; everything clears on reset, including coefficients
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            bin_q       <= ZERO_BIN;
            addr_q      <= {A_W{1'b0}};
            len_q       <= {A_W{1'b0}};
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_bin_q   <= 4'd0;
            res_t1_q    <= {D_W{1'b0}};
            res_t2_q    <= {D_W{1'b0}};
            done_q      <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                coeff_q[i] <= {D_W{1'b0}};
                t1_q[i]    <= {D_W{1'b0}};
                t2_q[i]    <= {D_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_bin_q   <= res_bin_d;
            res_t1_q    <= res_t1_d;
            res_t2_q    <= res_t2_d;
            done_q      <= done_d;
            coeff_q     <= coeff_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
        end
    end

    assign read_address = addr_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_bin      = res_bin_q;
    assign res_T1       = res_t1_q;
    assign res_T2       = res_t2_q;
    assign done         = done_q;

endmodule
